// File: rtl/morse_decoder.sv
// Morse line receiver: classifies tick-sampled mark/space runs
// and reports the decoded letter S..Z as a 3-bit index.
module morse_decoder #(
   parameter int LETTER_GAP = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick,
   input  logic       bit_in,
   output logic [2:0] letter,
   output logic       valid,
   output logic       error,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE,
      MARK,
      SPACE
   } state_t;

   localparam logic [2:0] GAP_M1 = 3'(LETTER_GAP - 1);

   state_t     state, state_nx;
   logic [2:0] mark_len, mark_len_nx;
   logic [2:0] space_len, space_len_nx;
   logic [2:0] n_elem, n_elem_nx;
   logic [3:0] sym, sym_nx;
   logic       err, err_nx;
   logic [2:0] letter_nx;
   logic       valid_nx, error_nx;
   logic       hit;
   logic [2:0] idx;

   // Table lookup of the collected element pattern.
   always_comb begin
      hit = 1'b1;
      idx = 3'd0;
      case ({n_elem, sym})
         7'b011_0000: idx = 3'd0;
         7'b001_0001: idx = 3'd1;
         7'b011_0100: idx = 3'd2;
         7'b100_1000: idx = 3'd3;
         7'b011_0110: idx = 3'd4;
         7'b100_1001: idx = 3'd5;
         7'b100_1101: idx = 3'd6;
         7'b100_0011: idx = 3'd7;
         default:     hit = 1'b0;
      endcase
   end

   // Next-state and next-output logic; everything holds unless tick.
   always_comb begin
      state_nx     = state;
      mark_len_nx  = mark_len;
      space_len_nx = space_len;
      n_elem_nx    = n_elem;
      sym_nx       = sym;
      err_nx       = err;
      letter_nx    = letter;
      valid_nx     = 1'b0;
      error_nx     = 1'b0;
      if (tick) begin
         unique case (state)
            IDLE: begin
               if (bit_in) begin
                  state_nx    = MARK;
                  mark_len_nx = 3'd1;
                  sym_nx      = 4'd0;
                  n_elem_nx   = 3'd0;
                  err_nx      = 1'b0;
               end
            end
            MARK: begin
               if (bit_in) begin
                  if (mark_len != 3'd7)
                     mark_len_nx = mark_len + 3'd1;
               end else begin
                  state_nx     = SPACE;
                  space_len_nx = 3'd1;
                  if (mark_len != 3'd1 && mark_len != 3'd3)
                     err_nx = 1'b1;
                  // A fifth element cannot fit in sym.
                  if (n_elem >= 3'd4)
                     err_nx = 1'b1;
                  else if (mark_len == 3'd3)
                     sym_nx[n_elem[1:0]] = 1'b1;
                  if (n_elem != 3'd7)
                     n_elem_nx = n_elem + 3'd1;
               end
            end
            SPACE: begin
               if (bit_in) begin
                  state_nx    = MARK;
                  mark_len_nx = 3'd1;
               end else if (space_len == GAP_M1) begin
                  state_nx = IDLE;
                  if (!err && hit) begin
                     valid_nx  = 1'b1;
                     letter_nx = idx;
                  end else begin
                     error_nx = 1'b1;
                  end
               end else begin
                  space_len_nx = space_len + 3'd1;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         mark_len  <= 3'd0;
         space_len <= 3'd0;
         n_elem    <= 3'd0;
         sym       <= 4'd0;
         err       <= 1'b0;
         letter    <= 3'd0;
         valid     <= 1'b0;
         error     <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nx;
         mark_len  <= mark_len_nx;
         space_len <= space_len_nx;
         n_elem    <= n_elem_nx;
         sym       <= sym_nx;
         err       <= err_nx;
         letter    <= letter_nx;
         valid     <= valid_nx;
         error     <= error_nx;
         busy      <= (state_nx != IDLE);
      end
   end

endmodule
